// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcode and funct constants, the decoded
// instruction record and immediate sign-extension helpers.
package riscv_pkg;

    localparam int RV_XLEN = 32;

    localparam logic [6:0] OPC_LOAD       = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM   = 7'b0001111;
    localparam logic [6:0] OPC_OP_ALU_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC      = 7'b0010111;
    localparam logic [6:0] OPC_STORE      = 7'b0100011;
    localparam logic [6:0] OPC_OP_ALU     = 7'b0110011;
    localparam logic [6:0] OPC_LUI        = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH     = 7'b1100011;
    localparam logic [6:0] OPC_JALR       = 7'b1100111;
    localparam logic [6:0] OPC_JAL        = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM     = 7'b1110011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_JALR    = 3'b000;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    typedef struct packed {
        logic [6:0]         opcode;
        logic [4:0]         rd;
        logic [2:0]         f3;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic [6:0]         f7;
        logic [RV_XLEN-1:0] imm;
        logic               is_imm;
    } instruction_t;

    function automatic logic [RV_XLEN-1:0] sext12(input logic [11:0] v);
        return {{(RV_XLEN-12){v[11]}}, v};
    endfunction

    function automatic logic [RV_XLEN-1:0] sext13(input logic [12:0] v);
        return {{(RV_XLEN-13){v[12]}}, v};
    endfunction

    function automatic logic [RV_XLEN-1:0] sext21(input logic [20:0] v);
        return {{(RV_XLEN-21){v[20]}}, v};
    endfunction

endpackage

// File: rtl/id_decoder.sv
// Combinational RV32I decoder: extracts fields per format, sign-extends the
// immediate and flags encodings outside the supported instruction set.
module id_decoder
    import riscv_pkg::*;
(
    input  logic [31:0]  instruction_i,
    output instruction_t instruction_o,
    output logic         illegal_o
);

    logic [6:0]   opcode_s;
    logic [6:0]   f7_s;
    logic [4:0]   rd_s;
    logic [4:0]   rs1_s;
    logic [4:0]   rs2_s;
    logic [2:0]   f3_s;
    logic         legal_s;
    instruction_t fields_s;

    assign opcode_s = instruction_i[6:0];
    assign rd_s     = instruction_i[11:7];
    assign f3_s     = instruction_i[14:12];
    assign rs1_s    = instruction_i[19:15];
    assign rs2_s    = instruction_i[24:20];
    assign f7_s     = instruction_i[31:25];

    // Field extraction and immediate formation by instruction format
    always_comb begin
        fields_s        = '0;
        fields_s.opcode = opcode_s;
        case (opcode_s)
            OPC_OP_ALU: begin
                fields_s.rd  = rd_s;
                fields_s.f3  = f3_s;
                fields_s.rs1 = rs1_s;
                fields_s.rs2 = rs2_s;
                fields_s.f7  = f7_s;
            end
            OPC_LOAD, OPC_OP_ALU_IMM, OPC_JALR, OPC_MISC_MEM, OPC_SYSTEM: begin
                fields_s.rd     = rd_s;
                fields_s.f3     = f3_s;
                fields_s.rs1    = rs1_s;
                fields_s.imm    = sext12(instruction_i[31:20]);
                fields_s.is_imm = 1'b1;
            end
            OPC_STORE: begin
                fields_s.f3     = f3_s;
                fields_s.rs1    = rs1_s;
                fields_s.rs2    = rs2_s;
                fields_s.imm    = sext12({instruction_i[31:25], instruction_i[11:7]});
                fields_s.is_imm = 1'b1;
            end
            OPC_BRANCH: begin
                fields_s.f3     = f3_s;
                fields_s.rs1    = rs1_s;
                fields_s.rs2    = rs2_s;
                fields_s.imm    = sext13({instruction_i[31], instruction_i[7],
                                          instruction_i[30:25], instruction_i[11:8], 1'b0});
                fields_s.is_imm = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                fields_s.rd     = rd_s;
                fields_s.imm    = RV_XLEN'({instruction_i[31:12], 12'h000});
                fields_s.is_imm = 1'b1;
            end
            OPC_JAL: begin
                fields_s.rd     = rd_s;
                fields_s.imm    = sext21({instruction_i[31], instruction_i[19:12],
                                          instruction_i[20], instruction_i[30:21], 1'b0});
                fields_s.is_imm = 1'b1;
            end
            default: begin
                fields_s.opcode = opcode_s;
            end
        endcase
    end

    // Encoding legality per opcode and funct fields
    always_comb begin
        legal_s = 1'b0;
        case (opcode_s)
            OPC_OP_ALU: begin
                if (f7_s == F7_BASE) begin
                    legal_s = 1'b1;
                end else if (f7_s == F7_ALT) begin
                    legal_s = (f3_s == F3_ADD_SUB) || (f3_s == F3_SRL_SRA);
                end else begin
                    legal_s = 1'b0;
                end
            end
            OPC_OP_ALU_IMM: begin
                // Only shifts reuse the upper immediate bits as a funct7
                if (f3_s == F3_SLL) begin
                    legal_s = (f7_s == F7_BASE);
                end else if (f3_s == F3_SRL_SRA) begin
                    legal_s = (f7_s == F7_BASE) || (f7_s == F7_ALT);
                end else begin
                    legal_s = 1'b1;
                end
            end
            OPC_LOAD: legal_s = (f3_s == F3_LB) || (f3_s == F3_LH) || (f3_s == F3_LW) ||
                                (f3_s == F3_LBU) || (f3_s == F3_LHU);
            OPC_STORE: legal_s = (f3_s == F3_SB) || (f3_s == F3_SH) || (f3_s == F3_SW);
            OPC_BRANCH: legal_s = (f3_s == F3_BEQ) || (f3_s == F3_BNE) || (f3_s == F3_BLT) ||
                                  (f3_s == F3_BGE) || (f3_s == F3_BLTU) || (f3_s == F3_BGEU);
            OPC_JALR: legal_s = (f3_s == F3_JALR);
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_MISC_MEM, OPC_SYSTEM: legal_s = 1'b1;
            default: legal_s = 1'b0;
        endcase
    end

    // Illegal words keep only the opcode so execute can trap on them
    always_comb begin
        instruction_o = '0;
        if (legal_s && (instruction_i[1:0] == 2'b11)) begin
            instruction_o = fields_s;
            illegal_o     = 1'b0;
        end else begin
            instruction_o.opcode = opcode_s;
            illegal_o            = 1'b1;
        end
    end

endmodule

// File: rtl/id_pipe_stage.sv
// Instruction-decode pipeline stage: decodes fetched words and buffers them
// with their PC in a small FIFO toward execute, with flush on redirect.
module id_pipe_stage
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     instruction_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output instruction_t    instruction_o,
    output logic [XLEN-1:0] pc_o,
    output logic            illegal_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        instruction_t    instr;
        logic [XLEN-1:0] pc;
        logic            illegal;
    } entry_t;

    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    entry_t           wr_entry_s;
    entry_t           head_s;
    instruction_t     dec_instr_s;
    logic             dec_illegal_s;
    logic             push_s;
    logic             pop_s;
    logic             in_ready_s;
    logic             out_valid_s;

    id_decoder u_id_decoder (
        .instruction_i (instruction_i),
        .instruction_o (dec_instr_s),
        .illegal_o     (dec_illegal_s)
    );

    assign wr_entry_s  = '{instr: dec_instr_s, pc: pc_i, illegal: dec_illegal_s};
    assign in_ready_s  = rst_ni && (count_q != CNT_W'(DEPTH));
    assign out_valid_s = (count_q != '0);
    assign push_s      = in_valid_i && in_ready_s;
    assign pop_s       = out_valid_s && out_ready_i;

    // Next-state for occupancy, pointers and storage; flush wins over both sides
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (flush_i) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_s) begin
                mem_d[wr_ptr_q] = wr_entry_s;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage; contents are only observable through a valid head
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    // Head presentation, forced to zero whenever nothing is buffered
    always_comb begin
        head_s = mem_q[rd_ptr_q];
        if (out_valid_s) begin
            instruction_o = head_s.instr;
            pc_o          = head_s.pc;
            illegal_o     = head_s.illegal;
        end else begin
            instruction_o = '0;
            pc_o          = '0;
            illegal_o     = 1'b0;
        end
    end

    assign out_valid_o = out_valid_s;
    assign in_ready_o  = in_ready_s;

endmodule

// File: tb/tb_id_pipe_stage.sv
// Self-checking bench for id_pipe_stage: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_id_pipe_stage;
    import riscv_pkg::*;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;

    typedef struct {
        instruction_t    ins;
        logic [XLEN-1:0] pc;
        logic            ill;
    } exp_t;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            flush_i;
    logic            in_valid_i;
    logic            in_ready_o;
    logic [31:0]     instruction_i;
    logic [XLEN-1:0] pc_i;
    logic            out_valid_o;
    logic            out_ready_i;
    instruction_t    instruction_o;
    logic [XLEN-1:0] pc_o;
    logic            illegal_o;

    int n_cmp = 0;
    int n_err = 0;
    exp_t model_q[$];

    always #5 clk_i = ~clk_i;

    id_pipe_stage #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .flush_i       (flush_i),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .instruction_i (instruction_i),
        .pc_i          (pc_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .instruction_o (instruction_o),
        .pc_o          (pc_o),
        .illegal_o     (illegal_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Reference decode straight from the ISA format rules, using signed arithmetic
    function automatic void model_decode(input logic [31:0] w, output instruction_t e, output logic ill);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        int         imm;
        bit         ok;
        op = w[6:0];
        f3 = w[14:12];
        f7 = w[31:25];
        e  = '0;
        ok = 1'b1;
        e.opcode = op;
        case (op)
            7'h33: begin
                ok = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5)));
                e.rd = w[11:7]; e.f3 = f3; e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.f7 = f7;
            end
            7'h13, 7'h03, 7'h67, 7'h0F, 7'h73: begin
                if (op == 7'h13 && f3 == 3'd1) ok = (f7 == 7'h00);
                if (op == 7'h13 && f3 == 3'd5) ok = (f7 == 7'h00) || (f7 == 7'h20);
                if (op == 7'h03) ok = !(f3 inside {3'd3, 3'd6, 3'd7});
                if (op == 7'h67) ok = (f3 == 3'd0);
                imm = $signed(w[31:20]);
                e.rd = w[11:7]; e.f3 = f3; e.rs1 = w[19:15]; e.imm = imm; e.is_imm = 1'b1;
            end
            7'h23: begin
                ok  = (f3 <= 3'd2);
                imm = $signed({w[31:25], w[11:7]});
                e.f3 = f3; e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.imm = imm; e.is_imm = 1'b1;
            end
            7'h63: begin
                ok  = !(f3 inside {3'd2, 3'd3});
                imm = $signed({w[31], w[7], w[30:25], w[11:8]}) * 2;
                e.f3 = f3; e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.imm = imm; e.is_imm = 1'b1;
            end
            7'h37, 7'h17: begin
                e.rd = w[11:7]; e.imm = w & 32'hFFFF_F000; e.is_imm = 1'b1;
            end
            7'h6F: begin
                imm = $signed({w[31], w[19:12], w[20], w[30:21]}) * 2;
                e.rd = w[11:7]; e.imm = imm; e.is_imm = 1'b1;
            end
            default: ok = 1'b0;
        endcase
        if (w[1:0] != 2'b11) ok = 1'b0;
        if (!ok) begin
            e = '0;
            e.opcode = op;
        end
        ill = !ok;
    endfunction

    function automatic logic [31:0] rand_word();
        logic [6:0]  ops [11] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33,
                                  7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};
        logic [31:0] w;
        int          sel;
        w   = $urandom;
        sel = $urandom_range(0, 9);
        if (sel != 0) w[6:0] = ops[$urandom_range(0, 10)];
        if (sel < 5) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        return w;
    endfunction

    task automatic test_reset();
        rst_ni = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        instruction_i = 32'h0; pc_i = '0;
        tick(); tick();
        n_cmp++; if (in_ready_o !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready_o); end
        n_cmp++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid_o); end
        n_cmp++; if (instruction_o !== '0) begin n_err++; $display("FAIL reset_instr: got %h want 0", instruction_o); end
        n_cmp++; if (pc_o !== '0 || illegal_o !== 1'b0) begin n_err++; $display("FAIL reset_pc_ill: got %h/%b want 0/0", pc_o, illegal_o); end
        rst_ni = 1'b1;
        #1;
        n_cmp++; if (in_ready_o !== 1'b1) begin n_err++; $display("FAIL release_in_ready: got %b want 1", in_ready_o); end
    endtask

    task automatic test_itype();
        out_ready_i = 1'b1; in_valid_i = 1'b1; instruction_i = 32'hFFF0_0093; pc_i = 32'h100;
        tick();
        in_valid_i = 1'b0;
        n_cmp++; if (out_valid_o !== 1'b1) begin n_err++; $display("FAIL itype_valid: got %b want 1", out_valid_o); end
        n_cmp++; if (instruction_o.rd !== 5'd1 || instruction_o.rs1 !== 5'd0) begin n_err++; $display("FAIL itype_regs: got rd=%0d rs1=%0d want 1/0", instruction_o.rd, instruction_o.rs1); end
        n_cmp++; if (instruction_o.imm !== 32'hFFFF_FFFF || instruction_o.is_imm !== 1'b1) begin n_err++; $display("FAIL itype_imm: got %h/%b want ffffffff/1", instruction_o.imm, instruction_o.is_imm); end
        n_cmp++; if (illegal_o !== 1'b0 || pc_o !== 32'h100) begin n_err++; $display("FAIL itype_pc_ill: got %h/%b want 100/0", pc_o, illegal_o); end
        tick();
        n_cmp++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL itype_drained: got %b want 0", out_valid_o); end
    endtask

    task automatic test_btype();
        out_ready_i = 1'b1; in_valid_i = 1'b1; instruction_i = 32'hFE00_0EE3; pc_i = 32'h180;
        tick();
        in_valid_i = 1'b0;
        n_cmp++; if (instruction_o.imm !== 32'hFFFF_FFFC || instruction_o.is_imm !== 1'b1) begin n_err++; $display("FAIL btype_imm: got %h/%b want fffffffc/1", instruction_o.imm, instruction_o.is_imm); end
        n_cmp++; if (instruction_o.f3 !== 3'd0 || instruction_o.rd !== 5'd0 || illegal_o !== 1'b0) begin n_err++; $display("FAIL btype_fields: got f3=%0d rd=%0d ill=%b want 0/0/0", instruction_o.f3, instruction_o.rd, illegal_o); end
        tick();
    endtask

    task automatic test_illegal();
        instruction_t exp_i;
        out_ready_i = 1'b1; in_valid_i = 1'b1; instruction_i = 32'h0000_0000; pc_i = 32'h200;
        tick();
        instruction_i = 32'h0000_1067; pc_i = 32'h204;
        exp_i = '0;
        n_cmp++; if (illegal_o !== 1'b1 || instruction_o !== exp_i || pc_o !== 32'h200) begin n_err++; $display("FAIL illegal_zero: got ill=%b ins=%h pc=%h want 1/%h/200", illegal_o, instruction_o, pc_o, exp_i); end
        tick();
        in_valid_i = 1'b0;
        exp_i.opcode = 7'h67;
        n_cmp++; if (illegal_o !== 1'b1 || instruction_o !== exp_i || pc_o !== 32'h204) begin n_err++; $display("FAIL illegal_jalr: got ill=%b ins=%h pc=%h want 1/%h/204", illegal_o, instruction_o, pc_o, exp_i); end
        tick();
        n_cmp++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL illegal_drained: got %b want 0", out_valid_o); end
    endtask

    task automatic test_backpressure();
        logic [31:0]     words [DEPTH];
        logic [XLEN-1:0] pcs   [DEPTH];
        instruction_t    e;
        logic            ill;
        for (int r = 0; r < 2; r++) begin
            if (r == 1) begin
                // One pass-through entry so the next fill wraps the pointers
                out_ready_i = 1'b1; in_valid_i = 1'b1; instruction_i = 32'h0010_0113; pc_i = 32'h2F0;
                tick();
                in_valid_i = 1'b0;
                tick();
            end
            out_ready_i = 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                words[k] = $urandom;
                words[k][6:0] = 7'h13;
                words[k][14:12] = 3'b000;
                pcs[k] = 32'h300 + 32'(r * 64 + k * 4);
                n_cmp++; if (in_ready_o !== 1'b1) begin n_err++; $display("FAIL bp_ready_before_%0d: got %b want 1", k, in_ready_o); end
                in_valid_i = 1'b1; instruction_i = words[k]; pc_i = pcs[k];
                tick();
            end
            instruction_i = 32'h0000_0013; pc_i = 32'h3F0; out_ready_i = 1'b1;
            n_cmp++; if (in_ready_o !== 1'b0 || out_valid_o !== 1'b1) begin n_err++; $display("FAIL bp_full: got rdy=%b vld=%b want 0/1", in_ready_o, out_valid_o); end
            for (int k = 0; k < DEPTH; k++) begin
                model_decode(words[k], e, ill);
                n_cmp++; if (out_valid_o !== 1'b1 || pc_o !== pcs[k] || instruction_o !== e) begin n_err++; $display("FAIL bp_order_%0d: got vld=%b pc=%h ins=%h want 1/%h/%h", k, out_valid_o, pc_o, instruction_o, pcs[k], e); end
                tick();
                in_valid_i = 1'b0;
            end
            n_cmp++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL bp_no_extra: got vld=%b pc=%h want 0", out_valid_o, pc_o); end
        end
    endtask

    task automatic test_flush();
        for (int fill = 1; fill <= DEPTH; fill++) begin
            out_ready_i = 1'b0;
            for (int k = 0; k < fill; k++) begin
                in_valid_i = 1'b1; instruction_i = 32'h0020_0093; pc_i = 32'h400 + 32'(k * 4);
                tick();
            end
            flush_i = 1'b1; in_valid_i = 1'b1; instruction_i = 32'h0050_0093; pc_i = 32'hDEAD0; out_ready_i = 1'b1;
            tick();
            flush_i = 1'b0; in_valid_i = 1'b0;
            n_cmp++; if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin n_err++; $display("FAIL flush_state_%0d: got vld=%b rdy=%b want 0/1", fill, out_valid_o, in_ready_o); end
            n_cmp++; if (instruction_o !== '0 || pc_o !== '0) begin n_err++; $display("FAIL flush_outputs_%0d: got %h/%h want 0/0", fill, instruction_o, pc_o); end
            tick(); tick();
            n_cmp++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL flush_dropped_%0d: got vld=%b pc=%h want 0", fill, out_valid_o, pc_o); end
        end
        in_valid_i = 1'b1; instruction_i = 32'h0030_0093; pc_i = 32'h480;
        tick();
        in_valid_i = 1'b0;
        n_cmp++; if (out_valid_o !== 1'b1 || pc_o !== 32'h480) begin n_err++; $display("FAIL flush_after: got vld=%b pc=%h want 1/480", out_valid_o, pc_o); end
        tick();
    endtask

    task automatic test_reset_mid();
        instruction_t e;
        logic         ill;
        out_ready_i = 1'b0; in_valid_i = 1'b1; instruction_i = 32'h0040_0093; pc_i = 32'h500;
        tick();
        in_valid_i = 1'b0;
        n_cmp++; if (out_valid_o !== 1'b1) begin n_err++; $display("FAIL rmid_buffered: got %b want 1", out_valid_o); end
        rst_ni = 1'b0;
        tick();
        n_cmp++; if (out_valid_o !== 1'b0 || in_ready_o !== 1'b0 || instruction_o !== '0 || pc_o !== '0 || illegal_o !== 1'b0) begin n_err++; $display("FAIL rmid_cleared: got vld=%b rdy=%b ins=%h pc=%h ill=%b want all 0", out_valid_o, in_ready_o, instruction_o, pc_o, illegal_o); end
        rst_ni = 1'b1; in_valid_i = 1'b1; instruction_i = 32'h0000_50B7; pc_i = 32'h600;
        tick();
        in_valid_i = 1'b0;
        model_decode(32'h0000_50B7, e, ill);
        n_cmp++; if (out_valid_o !== 1'b1 || pc_o !== 32'h600 || instruction_o !== e || illegal_o !== ill) begin n_err++; $display("FAIL rmid_first: got vld=%b pc=%h ins=%h want 1/600/%h", out_valid_o, pc_o, instruction_o, e); end
        out_ready_i = 1'b1;
        tick();
        n_cmp++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL rmid_drained: got %b want 0", out_valid_o); end
    endtask

    task automatic test_random();
        exp_t         x;
        instruction_t zero_i;
        bit           push;
        bit           pop;
        zero_i = '0;
        flush_i = 1'b1; in_valid_i = 1'b0;
        tick();
        flush_i = 1'b0;
        model_q.delete();
        for (int c = 0; c < 600; c++) begin
            in_valid_i    = ($urandom_range(0, 3) != 0);
            out_ready_i   = ($urandom_range(0, 2) != 0);
            flush_i       = ($urandom_range(0, 24) == 0);
            instruction_i = rand_word();
            pc_i          = $urandom;
            n_cmp++; if (out_valid_o !== (model_q.size() != 0)) begin n_err++; $display("FAIL rnd_valid c=%0d: got %b want %b", c, out_valid_o, model_q.size() != 0); end
            n_cmp++; if (in_ready_o !== (model_q.size() != DEPTH)) begin n_err++; $display("FAIL rnd_ready c=%0d: got %b want %b", c, in_ready_o, model_q.size() != DEPTH); end
            if (model_q.size() != 0) begin
                n_cmp++; if (instruction_o !== model_q[0].ins || pc_o !== model_q[0].pc || illegal_o !== model_q[0].ill) begin n_err++; $display("FAIL rnd_head c=%0d: got %h/%h/%b want %h/%h/%b", c, instruction_o, pc_o, illegal_o, model_q[0].ins, model_q[0].pc, model_q[0].ill); end
            end else begin
                n_cmp++; if (instruction_o !== zero_i || pc_o !== '0 || illegal_o !== 1'b0) begin n_err++; $display("FAIL rnd_idle c=%0d: got %h/%h/%b want 0", c, instruction_o, pc_o, illegal_o); end
            end
            push = in_valid_i && (model_q.size() != DEPTH);
            pop  = (model_q.size() != 0) && out_ready_i;
            if (flush_i) begin
                model_q.delete();
            end else begin
                if (pop) void'(model_q.pop_front());
                if (push) begin
                    model_decode(instruction_i, x.ins, x.ill);
                    x.pc = pc_i;
                    model_q.push_back(x);
                end
            end
            tick();
        end
        in_valid_i = 1'b0; flush_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_itype();
        test_btype();
        test_illegal();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
